// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types: FSM state encoding and default operand width.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result valid-ready bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: x - y - bi.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin: one difference bit per clock, LSB first, through one full-subtractor cell.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_n;
    logic             in_ready_q, out_valid_q;
    logic             in_ready_n, out_valid_n;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             d_c, bo_c, last_c;
    logic [WIDTH-1:0] res_c;

    full_subtractor u_fs (
        .x (sa[0]),
        .y (sb[0]),
        .bi(br),
        .d (d_c),
        .bo(bo_c)
    );

    assign last_c = (cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 of the result is the first bit computed.
    assign res_c  = {d_c, res};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_n = RUN;
            RUN:     if (last_c)        state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
    end

    // Operand shifters, borrow chain, bit counter and result holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        br  <= bus.bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= bo_c;
                    res <= res_c[WIDTH-1:1];
                    cnt <= cnt + CW'(1);
                    if (last_c) begin
                        diff_q <= res_c;
                        bout_q <= bo_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial A − B − Bin engine. It is the inverse-operation counterpart to the team's 4-bit carry-select adder.
- Accepts one operand pair through a valid/ready handshake and resolves one difference bit per clock, LSB first, through a single full-subtractor cell.
- Presents {bout, diff} on a valid/ready output. It slots into the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 4, operand and difference width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- States (shared enum): IDLE, RUN, DONE.
- Reset (rst high at a rising edge):
  - State goes to IDLE; in_ready=1, out_valid=0, diff=0, bout=0.
  - The bit counter and operand shift registers clear.
  - Reset wins over every other input, including mid-RUN and in DONE; any in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b, bin into shift registers sa, sb and borrow register br. Clear counter cnt, go to RUN.
  - Operands are sampled only on that edge; later changes to a/b/bin are ignored.
- RUN (in_ready=0, out_valid=0): on each edge
  - d = sa[0]^sb[0]^br
  - br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
  - d shifts into the MSB of a result shift register, then sa and sb shift right; cnt increments.
  - On the edge where cnt == WIDTH−1: load diff from the completed result, load bout from the final br, go to DONE.
- Latency:
  - Accept at edge T; out_valid rises after edge T+WIDTH (WIDTH cycles in RUN).
  - Minimum throughput is one operation per WIDTH+2 cycles.
- DONE:
  - out_valid=1; diff and bout hold stable until handshake.
  - On an edge with out_ready=1: out_valid→0, go to IDLE, in_ready→1 after that edge.
  - diff and bout keep their last value in IDLE and RUN; they change only when the block enters DONE or on reset.
- Inputs during RUN/DONE: in_valid is ignored. The upstream producer holds its data (standard valid/ready); no operands are dropped or overwritten.
- Unbounded out_ready=0 stall: the block remains in DONE indefinitely with outputs stable.
- Arithmetic boundaries:
  - Wrap-around is modulo 2^WIDTH, with bout reflecting the borrow.
  - a=b, bin=0 → diff=0, bout=0.
  - a=0, b=2^WIDTH−1, bin=1 → diff=0, bout=1.
- cnt width is $clog2(WIDTH); no X propagation allowed out of reset.

Decomposition:
- Shared package arith_pkg holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2; encoding 2'd3 recovers to IDLE);
  - a localparam for the default width (4).
- One natural sub-module: full_subtractor. It is combinational, with inputs x, y, bi and outputs d, bo, and is instantiated once inside the serial datapath.
- The FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- a=8, b=3, bin=0 → after 4 RUN cycles out_valid=1, diff=5, bout=0; out_ready=1 on the same cycle → IDLE, in_ready=1 next cycle.
- a=3, b=10, bin=1 → diff=8, bout=1. Then a=6, b=6, bin=0 → diff=0, bout=0. Check that in_ready is low throughout the RUN states.
- a=7, b=14, bin=0 → diff=9, bout=1. Hold out_ready=0 for 10 cycles → out_valid, diff and bout stable. Toggle a/b/in_valid during the stall → no effect.
- a=14, b=14, bin=1 → diff=15, bout=1. a=0, b=15, bin=1 → diff=0, bout=1 (full wrap).
- Assert rst for one cycle after 2 RUN cycles (a=9, b=4) → next cycle IDLE, in_ready=1, out_valid=0, diff=0, bout=0. A fresh a=9, b=4, bin=0 afterwards → diff=5, bout=0.
- Back-to-back: in_valid held high with 3 queued operand pairs and out_ready tied 1 → each result is correct, and there are exactly WIDTH+2 cycles between successive out_valid pulses.
